// File: rtl/wb_cmd_master.sv
// wb_cmd_master: command-FIFO driven single-beat Wishbone initiator.
// Commands queue in a small FIFO, each one becomes a single WBs_* cycle that
// ends on WBs_ACK_i or on a timeout, and the result is returned on Rsp_*.
module wb_cmd_master #(
    parameter int ADDRWIDTH = 17,
    parameter int DATAWIDTH = 32,
    parameter int CMD_FIFO_DEPTH = 4,
    parameter int DEFAULT_CNTR_WIDTH = 3,
    parameter int DEFAULT_CNTR_TIMEOUT = 7,
    parameter logic [DATAWIDTH-1:0] DEFAULT_READ_VALUE = 32'hBAD_FAB_AC
) (
    input  logic                 WB_CLK,
    input  logic                 WB_RST_n,
    input  logic                 Cmd_Valid_i,
    output logic                 Cmd_Ready_o,
    input  logic [ADDRWIDTH-1:0] Cmd_Adr_i,
    input  logic                 Cmd_WE_i,
    input  logic [3:0]           Cmd_Byte_Stb_i,
    input  logic [DATAWIDTH-1:0] Cmd_Wr_Dat_i,
    output logic                 Rsp_Valid_o,
    input  logic                 Rsp_Ready_i,
    output logic [DATAWIDTH-1:0] Rsp_Rd_Dat_o,
    output logic                 Rsp_WE_o,
    output logic                 Rsp_Err_o,
    output logic [ADDRWIDTH-1:0] WBs_ADR_o,
    output logic                 WBs_CYC_o,
    output logic                 WBs_STB_o,
    output logic                 WBs_WE_o,
    output logic                 WBs_RD_o,
    output logic [3:0]           WBs_BYTE_STB_o,
    output logic [DATAWIDTH-1:0] WBs_WR_DAT_o,
    input  logic [DATAWIDTH-1:0] WBs_RD_DAT_i,
    input  logic                 WBs_ACK_i,
    output logic                 Busy_o
);

    localparam int PTRW = (CMD_FIFO_DEPTH > 1) ? $clog2(CMD_FIFO_DEPTH) : 1;
    localparam int ENTW = ADDRWIDTH + 1 + 4 + DATAWIDTH;
    localparam int CW   = DEFAULT_CNTR_WIDTH;

    localparam logic [PTRW:0]   FULL_CNT = (PTRW+1)'(CMD_FIFO_DEPTH);
    localparam logic [PTRW:0]   ONE_CNT  = {{PTRW{1'b0}}, 1'b1};
    localparam logic [PTRW-1:0] ONE_PTR  = {{(PTRW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0]   TERM_CNT = CW'(DEFAULT_CNTR_TIMEOUT);
    localparam logic [CW-1:0]   ONE_TMO  = {{(CW-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RSP  = 2'd2
    } state_e;

    // FIFO storage and bookkeeping
    logic [ENTW-1:0]  fifo_mem_q [CMD_FIFO_DEPTH];
    logic [PTRW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [PTRW:0]    count_q, count_d;
    logic             full_q, full_d;
    logic             push_s, pop_s, empty_s;
    logic [ENTW-1:0]  head_s;

    // FSM state, timeout counter and registered outputs
    state_e                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [ADDRWIDTH-1:0]  adr_q, adr_d;
    logic                  cyc_q, cyc_d;
    logic                  stb_q, stb_d;
    logic                  we_q, we_d;
    logic                  rd_q, rd_d;
    logic [3:0]            bs_q, bs_d;
    logic [DATAWIDTH-1:0]  wdat_q, wdat_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATAWIDTH-1:0]  rsp_dat_q, rsp_dat_d;
    logic                  rsp_we_q, rsp_we_d;
    logic                  rsp_err_q, rsp_err_d;
    logic                  busy_q, busy_d;

    // Full is a registered flag: a full FIFO refuses even when popping this edge.
    assign push_s  = Cmd_Valid_i & ~full_q;
    assign empty_s = (count_q == {(PTRW+1){1'b0}});
    assign head_s  = fifo_mem_q[rd_ptr_q];

    // FIFO occupancy next state
    always_comb begin
        count_d = count_q;
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + ONE_CNT;
            2'b01:   count_d = count_q - ONE_CNT;
            default: count_d = count_q;
        endcase
        full_d = (count_d == FULL_CNT);
    end

    // FIFO storage write and pointer/occupancy registers
    always_ff @(posedge WB_CLK or negedge WB_RST_n) begin
        if (!WB_RST_n) begin
            for (int i = 0; i < CMD_FIFO_DEPTH; i++) begin
                fifo_mem_q[i] <= {ENTW{1'b0}};
            end
            wr_ptr_q <= {PTRW{1'b0}};
            rd_ptr_q <= {PTRW{1'b0}};
            count_q  <= {(PTRW+1){1'b0}};
            full_q   <= 1'b0;
        end else begin
            if (push_s) begin
                fifo_mem_q[wr_ptr_q] <= {Cmd_Adr_i, Cmd_WE_i, Cmd_Byte_Stb_i, Cmd_Wr_Dat_i};
                wr_ptr_q             <= wr_ptr_q + ONE_PTR;
            end
            if (pop_s) begin
                rd_ptr_q <= rd_ptr_q + ONE_PTR;
            end
            count_q <= count_d;
            full_q  <= full_d;
        end
    end

    // Bus FSM: issue one cycle, wait for ACK or timeout, hold response until taken
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        adr_d       = adr_q;
        cyc_d       = cyc_q;
        stb_d       = stb_q;
        we_d        = we_q;
        rd_d        = rd_q;
        bs_d        = bs_q;
        wdat_d      = wdat_q;
        rsp_valid_d = rsp_valid_q;
        rsp_dat_d   = rsp_dat_q;
        rsp_we_d    = rsp_we_q;
        rsp_err_d   = rsp_err_q;
        pop_s       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!empty_s) begin
                    pop_s   = 1'b1;
                    {adr_d, we_d, bs_d, wdat_d} = head_s;
                    rd_d    = ~head_s[DATAWIDTH+4];
                    cyc_d   = 1'b1;
                    stb_d   = 1'b1;
                    cnt_d   = {CW{1'b0}};
                    state_d = ST_REQ;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (WBs_ACK_i || (cnt_q == TERM_CNT)) begin
                    // ACK wins over a timeout on the terminal-count edge
                    if (WBs_ACK_i) begin
                        rsp_dat_d = we_q ? {DATAWIDTH{1'b0}} : WBs_RD_DAT_i;
                        rsp_err_d = 1'b0;
                    end else begin
                        rsp_dat_d = we_q ? {DATAWIDTH{1'b0}} : DEFAULT_READ_VALUE;
                        rsp_err_d = 1'b1;
                    end
                    rsp_we_d    = we_q;
                    rsp_valid_d = 1'b1;
                    adr_d       = {ADDRWIDTH{1'b0}};
                    cyc_d       = 1'b0;
                    stb_d       = 1'b0;
                    we_d        = 1'b0;
                    rd_d        = 1'b0;
                    bs_d        = 4'h0;
                    wdat_d      = {DATAWIDTH{1'b0}};
                    state_d     = ST_RSP;
                end else begin
                    cnt_d = cnt_q + ONE_TMO;
                end
            end
            ST_RSP: begin
                if (Rsp_Ready_i) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end else begin
                    state_d = ST_RSP;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                rsp_valid_d = 1'b0;
                adr_d       = {ADDRWIDTH{1'b0}};
                cyc_d       = 1'b0;
                stb_d       = 1'b0;
                we_d        = 1'b0;
                rd_d        = 1'b0;
                bs_d        = 4'h0;
                wdat_d      = {DATAWIDTH{1'b0}};
            end
        endcase
        busy_d = (state_d != ST_IDLE) | (count_d != {(PTRW+1){1'b0}});
    end

    // FSM state and registered output flops
    always_ff @(posedge WB_CLK or negedge WB_RST_n) begin
        if (!WB_RST_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= {CW{1'b0}};
            adr_q       <= {ADDRWIDTH{1'b0}};
            cyc_q       <= 1'b0;
            stb_q       <= 1'b0;
            we_q        <= 1'b0;
            rd_q        <= 1'b0;
            bs_q        <= 4'h0;
            wdat_q      <= {DATAWIDTH{1'b0}};
            rsp_valid_q <= 1'b0;
            rsp_dat_q   <= {DATAWIDTH{1'b0}};
            rsp_we_q    <= 1'b0;
            rsp_err_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            adr_q       <= adr_d;
            cyc_q       <= cyc_d;
            stb_q       <= stb_d;
            we_q        <= we_d;
            rd_q        <= rd_d;
            bs_q        <= bs_d;
            wdat_q      <= wdat_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_dat_q   <= rsp_dat_d;
            rsp_we_q    <= rsp_we_d;
            rsp_err_q   <= rsp_err_d;
            busy_q      <= busy_d;
        end
    end

    assign Cmd_Ready_o    = ~full_q;
    assign Rsp_Valid_o    = rsp_valid_q;
    assign Rsp_Rd_Dat_o   = rsp_dat_q;
    assign Rsp_WE_o       = rsp_we_q;
    assign Rsp_Err_o      = rsp_err_q;
    assign WBs_ADR_o      = adr_q;
    assign WBs_CYC_o      = cyc_q;
    assign WBs_STB_o      = stb_q;
    assign WBs_WE_o       = we_q;
    assign WBs_RD_o       = rd_q;
    assign WBs_BYTE_STB_o = bs_q;
    assign WBs_WR_DAT_o   = wdat_q;
    assign Busy_o         = busy_q;

endmodule

// File: tb/tb_wb_cmd_master.sv
// Testbench for wb_cmd_master: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a transaction-level model.
module tb_wb_cmd_master;

    localparam int AW    = 17;
    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam logic [DW-1:0] BAD = 32'hBADFABAC;

    logic           WB_CLK = 1'b0;
    logic           WB_RST_n = 1'b0;
    logic           Cmd_Valid_i = 1'b0;
    logic           Cmd_Ready_o;
    logic [AW-1:0]  Cmd_Adr_i = '0;
    logic           Cmd_WE_i = 1'b0;
    logic [3:0]     Cmd_Byte_Stb_i = 4'h0;
    logic [DW-1:0]  Cmd_Wr_Dat_i = '0;
    logic           Rsp_Valid_o;
    logic           Rsp_Ready_i = 1'b0;
    logic [DW-1:0]  Rsp_Rd_Dat_o;
    logic           Rsp_WE_o;
    logic           Rsp_Err_o;
    logic [AW-1:0]  WBs_ADR_o;
    logic           WBs_CYC_o;
    logic           WBs_STB_o;
    logic           WBs_WE_o;
    logic           WBs_RD_o;
    logic [3:0]     WBs_BYTE_STB_o;
    logic [DW-1:0]  WBs_WR_DAT_o;
    logic [DW-1:0]  WBs_RD_DAT_i = '0;
    logic           WBs_ACK_i = 1'b0;
    logic           Busy_o;

    wb_cmd_master dut (
        .WB_CLK(WB_CLK), .WB_RST_n(WB_RST_n),
        .Cmd_Valid_i(Cmd_Valid_i), .Cmd_Ready_o(Cmd_Ready_o), .Cmd_Adr_i(Cmd_Adr_i),
        .Cmd_WE_i(Cmd_WE_i), .Cmd_Byte_Stb_i(Cmd_Byte_Stb_i), .Cmd_Wr_Dat_i(Cmd_Wr_Dat_i),
        .Rsp_Valid_o(Rsp_Valid_o), .Rsp_Ready_i(Rsp_Ready_i), .Rsp_Rd_Dat_o(Rsp_Rd_Dat_o),
        .Rsp_WE_o(Rsp_WE_o), .Rsp_Err_o(Rsp_Err_o),
        .WBs_ADR_o(WBs_ADR_o), .WBs_CYC_o(WBs_CYC_o), .WBs_STB_o(WBs_STB_o),
        .WBs_WE_o(WBs_WE_o), .WBs_RD_o(WBs_RD_o), .WBs_BYTE_STB_o(WBs_BYTE_STB_o),
        .WBs_WR_DAT_o(WBs_WR_DAT_o), .WBs_RD_DAT_i(WBs_RD_DAT_i), .WBs_ACK_i(WBs_ACK_i),
        .Busy_o(Busy_o)
    );

    always #5 WB_CLK = ~WB_CLK;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic [AW-1:0] adr;
        logic          we;
        logic [3:0]    bs;
        logic [DW-1:0] dat;
    } cmd_t;

    cmd_t          m_q[$];
    cmd_t          m_cur;
    bit            m_inflight = 0;
    bit            m_rsp_pend = 0;
    int            m_cyc_cycles = 0;
    logic [DW-1:0] m_rd = '0;
    bit            m_err = 0;
    bit            m_we = 0;
    bit            m_accept = 0;

    initial begin : model
        forever begin
            @(posedge WB_CLK or negedge WB_RST_n);
            if (!WB_RST_n) begin
                m_q.delete();
                m_inflight = 0; m_rsp_pend = 0; m_cyc_cycles = 0;
                m_rd = '0; m_err = 0; m_we = 0; m_accept = 0;
            end else begin
                cmd_t nc;
                bit acc;
                acc = Cmd_Valid_i && (m_q.size() < DEPTH);
                nc  = '{Cmd_Adr_i, Cmd_WE_i, Cmd_Byte_Stb_i, Cmd_Wr_Dat_i};
                if (m_inflight) begin
                    if (WBs_ACK_i) begin
                        m_rd = m_cur.we ? '0 : WBs_RD_DAT_i;
                        m_err = 0; m_we = m_cur.we; m_inflight = 0; m_rsp_pend = 1;
                    end else if (m_cyc_cycles == 8) begin
                        m_rd = m_cur.we ? '0 : BAD;
                        m_err = 1; m_we = m_cur.we; m_inflight = 0; m_rsp_pend = 1;
                    end else begin
                        m_cyc_cycles++;
                    end
                end else if (m_rsp_pend) begin
                    if (Rsp_Ready_i) m_rsp_pend = 0;
                end else if (m_q.size() > 0) begin
                    m_cur = m_q.pop_front();
                    m_inflight = 1;
                    m_cyc_cycles = 1;
                end
                if (acc) m_q.push_back(nc);
                m_accept = acc;
            end
        end
    end

    // Every-cycle comparison of DUT outputs against the model
    initial begin : compare
        forever begin
            @(negedge WB_CLK);
            if (WB_RST_n) begin
                logic [56:0] wexp;
                wexp = m_inflight ? {m_cur.adr, 1'b1, 1'b1, m_cur.we, ~m_cur.we, m_cur.bs, m_cur.dat} : 57'd0;
                check("wbs_bus", {WBs_ADR_o, WBs_CYC_o, WBs_STB_o, WBs_WE_o, WBs_RD_o, WBs_BYTE_STB_o, WBs_WR_DAT_o}, wexp);
                check("rsp_if", {Rsp_Valid_o, Rsp_Rd_Dat_o, Rsp_WE_o, Rsp_Err_o}, {m_rsp_pend, m_rd, m_we, m_err});
                check("ready_busy", {Cmd_Ready_o, Busy_o},
                      {m_q.size() < DEPTH, m_inflight || m_rsp_pend || (m_q.size() > 0)});
            end
        end
    end

    // ---------------- slave, response sink, monitor ----------------
    int            plan_lat[$];
    logic [DW-1:0] plan_dat[$];
    bit            stray_en = 0;
    bit            force_ack = 0;
    int            rsp_mode = 0;   // 0 hold off, 1 always ready, 2 random

    initial begin : slave
        int s_age = 0;
        int s_lat = 0;
        logic [DW-1:0] s_dat = '0;
        forever begin
            @(posedge WB_CLK); #2;
            if (WBs_CYC_o) begin
                if (s_age == 0) begin
                    if (plan_lat.size() > 0) begin
                        s_lat = plan_lat.pop_front();
                        s_dat = plan_dat.pop_front();
                    end else begin
                        s_lat = $urandom_range(0, 9);
                        s_dat = $urandom;
                    end
                end
                s_age++;
                WBs_RD_DAT_i = s_dat;
                WBs_ACK_i = (s_age == s_lat);
            end else begin
                s_age = 0;
                WBs_RD_DAT_i = $urandom;
                WBs_ACK_i = force_ack || (stray_en && ($urandom_range(0, 3) == 0));
            end
        end
    end

    initial begin : rsp_sink
        forever begin
            @(posedge WB_CLK); #2;
            Rsp_Ready_i = (rsp_mode == 1) ? 1'b1 : (rsp_mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
        end
    end

    typedef struct { logic [DW-1:0] dat; logic err; logic we; } rsp_t;
    rsp_t rsp_log[$];
    int   cyc_len_cur = 0;
    int   cyc_last_len = 0;
    int   cyc_count = 0;

    initial begin : monitor
        forever begin
            @(negedge WB_CLK);
            if (!WB_RST_n) begin
                cyc_len_cur = 0;
            end else begin
                if (WBs_CYC_o) cyc_len_cur++;
                else if (cyc_len_cur > 0) begin
                    cyc_last_len = cyc_len_cur; cyc_len_cur = 0; cyc_count++;
                end
                if (Rsp_Valid_o && Rsp_Ready_i) rsp_log.push_back('{Rsp_Rd_Dat_o, Rsp_Err_o, Rsp_WE_o});
            end
        end
    end

    // ---------------- driver tasks (all end at posedge+2) ----------------
    task automatic cycles(input int n);
        repeat (n) begin @(posedge WB_CLK); #2; end
    endtask

    task automatic send_cmd(input logic [AW-1:0] a, input logic we, input logic [3:0] bs, input logic [DW-1:0] d);
        bit acc = 0;
        Cmd_Adr_i = a; Cmd_WE_i = we; Cmd_Byte_Stb_i = bs; Cmd_Wr_Dat_i = d; Cmd_Valid_i = 1'b1;
        for (int i = 0; i < 300 && !acc; i++) begin
            @(posedge WB_CLK); #1; acc = m_accept; #1;
        end
        Cmd_Valid_i = 1'b0;
        check("push_accepted", acc, 1);
    endtask

    task automatic try_push(input cmd_t c, output bit acc);
        Cmd_Adr_i = c.adr; Cmd_WE_i = c.we; Cmd_Byte_Stb_i = c.bs; Cmd_Wr_Dat_i = c.dat; Cmd_Valid_i = 1'b1;
        @(posedge WB_CLK); #1; acc = m_accept; #1;
    endtask

    task automatic wait_rsp(input int n);
        int i = 0;
        while (rsp_log.size() < n && i < 500) begin @(posedge WB_CLK); #2; i++; end
        check("rsp_arrived", rsp_log.size() >= n, 1);
    endtask

    task automatic plan(input int lat, input logic [DW-1:0] d);
        plan_lat.push_back(lat); plan_dat.push_back(d);
    endtask

    task automatic expect_rsp(input string name, input logic [DW-1:0] d, input logic err, input logic we);
        rsp_t r;
        if (rsp_log.size() > 0) begin
            r = rsp_log.pop_front();
            check(name, {r.dat, r.err, r.we}, {d, err, we});
        end else begin
            check({name, "_missing"}, 1'b0, 1'b1);
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin : main
        bit   acc;
        int   acc_cnt;
        int   cyc_before;
        cmd_t c;

        #23 WB_RST_n = 1'b1;
        @(posedge WB_CLK); #2;
        check("reset_state", {Cmd_Ready_o, WBs_CYC_o, WBs_STB_o, Rsp_Valid_o, Busy_o, Rsp_Rd_Dat_o, Rsp_Err_o},
              {1'b1, 4'b0000, 32'h0, 1'b0});
        rsp_mode = 1;
        cycles(2);

        // single write, ACK in the third CYC cycle
        plan(3, 32'h0);
        send_cmd(17'h01004, 1'b1, 4'hF, 32'h000000A5);
        wait_rsp(1);
        expect_rsp("write_rsp", 32'h0, 1'b0, 1'b1);
        check("write_cyc_len", cyc_last_len, 3);

        // single read, ACK in the first CYC cycle
        plan(1, 32'h12345678);
        send_cmd(17'h00000, 1'b0, 4'hF, 32'h0);
        wait_rsp(1);
        expect_rsp("read_rsp", 32'h12345678, 1'b0, 1'b0);
        check("read_cyc_len", cyc_last_len, 1);

        // read timeout
        plan(0, 32'h0);
        send_cmd(17'h1FFFC, 1'b0, 4'h3, 32'h0);
        wait_rsp(1);
        expect_rsp("timeout_rsp", BAD, 1'b1, 1'b0);
        check("timeout_cyc_len", cyc_last_len, 8);

        // ACK on the terminal-count cycle wins
        plan(8, 32'h5A5A0F0F);
        send_cmd(17'h00100, 1'b0, 4'hF, 32'h0);
        wait_rsp(1);
        expect_rsp("late_ack_rsp", 32'h5A5A0F0F, 1'b0, 1'b0);
        check("late_ack_cyc_len", cyc_last_len, 8);

        // write timeout returns zero data with error
        plan(0, 32'h0);
        send_cmd(17'h00200, 1'b1, 4'h1, 32'hDEADBEEF);
        wait_rsp(1);
        expect_rsp("wr_timeout_rsp", 32'h0, 1'b1, 1'b1);

        // back-pressure: one response parked, then five back-to-back pushes
        rsp_mode = 0;
        cycles(2);
        plan(2, 32'h0);
        send_cmd(17'h00010, 1'b1, 4'hF, 32'h11111111);
        for (int i = 0; i < 50 && !Rsp_Valid_o; i++) cycles(1);
        check("bp_rsp_parked", Rsp_Valid_o, 1'b1);
        for (int i = 0; i < 4; i++) plan(1, 32'hA0000000 + 32'(i));
        acc_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            c = '{17'h00020 + 17'(4 * i), 1'b0, 4'hF, 32'h0};
            try_push(c, acc);
            acc_cnt += int'(acc);
        end
        Cmd_Valid_i = 1'b0;
        check("bp_accepted", acc_cnt, 4);
        check("bp_ready_low", Cmd_Ready_o, 1'b0);
        rsp_mode = 1;
        wait_rsp(5);
        expect_rsp("bp_rsp0", 32'h0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) expect_rsp("bp_rsp_order", 32'hA0000000 + 32'(i), 1'b0, 1'b0);
        plan(1, 32'hA0000004);
        send_cmd(17'h00030, 1'b0, 4'hF, 32'h0);
        wait_rsp(1);
        expect_rsp("bp_fifth", 32'hA0000004, 1'b0, 1'b0);

        // reset in the middle of a cycle with another command queued
        cycles(2);
        plan(0, 32'h0);
        send_cmd(17'h00040, 1'b0, 4'hF, 32'h0);
        send_cmd(17'h00044, 1'b0, 4'hF, 32'h0);
        cycles(2);
        check("pre_reset_cyc", WBs_CYC_o, 1'b1);
        #1 WB_RST_n = 1'b0;
        #1 check("rst_async", {WBs_CYC_o, WBs_STB_o, Rsp_Valid_o, Busy_o}, 4'b0000);
        plan_lat.delete(); plan_dat.delete();
        cycles(2);
        #1 WB_RST_n = 1'b1;
        @(posedge WB_CLK); #2;
        cyc_before = cyc_count;
        cycles(5);
        check("post_reset_idle", {Busy_o, WBs_CYC_o, Cmd_Ready_o}, 3'b001);
        check("post_reset_no_cyc", cyc_count, cyc_before);
        rsp_log.delete();
        plan(2, 32'hCAFE0001);
        send_cmd(17'h00048, 1'b0, 4'hF, 32'h0);
        wait_rsp(1);
        expect_rsp("post_reset_read", 32'hCAFE0001, 1'b0, 1'b0);

        // stray ACKs in IDLE and in RSP
        rsp_mode = 0;
        cycles(2);
        cyc_before = cyc_count;
        force_ack = 1; cycles(3); force_ack = 0; cycles(1);
        check("stray_idle", {Busy_o, Rsp_Valid_o}, 2'b00);
        plan(1, 32'h0);
        send_cmd(17'h00050, 1'b1, 4'hF, 32'h22222222);
        for (int i = 0; i < 50 && !Rsp_Valid_o; i++) cycles(1);
        force_ack = 1; cycles(3); force_ack = 0; cycles(1);
        check("stray_rsp_hold", {Rsp_Valid_o, Rsp_Rd_Dat_o, Rsp_Err_o, Rsp_WE_o}, {1'b1, 32'h0, 1'b0, 1'b1});
        check("stray_one_cycle", cyc_count - cyc_before, 1);
        rsp_mode = 1;
        wait_rsp(1);
        expect_rsp("stray_rsp", 32'h0, 1'b0, 1'b1);
        check("stray_no_extra", rsp_log.size(), 0);

        // randomized traffic
        stray_en = 1;
        rsp_mode = 2;
        for (int n = 0; n < 300; n++) begin
            send_cmd(17'($urandom), 1'($urandom), 4'($urandom), $urandom);
            cycles($urandom_range(0, 2));
        end
        rsp_mode = 1;
        for (int i = 0; i < 1000 && (Busy_o || Rsp_Valid_o); i++) cycles(1);
        check("drain_idle", {Busy_o, Rsp_Valid_o}, 2'b00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/wb_cmd_master.md
Name: wb_cmd_master

Overview:
- Wishbone initiator for fabric-side logic: it drives the same WBs_* cycle format that the FPGA IP register/UART blocks respond to.
- Accepts read/write commands over a valid/ready interface and buffers them in a small command FIFO.
- Issues one single-beat Wishbone cycle per command and waits for WBs_ACK or a timeout.
- Returns read data and error status over a valid/ready response interface.
- Used as a bus-functional master for fabric-internal test and bring-up, and as the initiator end of bridges (e.g. UART-to-WB).

Parameters:
ADDRWIDTH, 17, Wishbone byte address width
DATAWIDTH, 32, data bus width
CMD_FIFO_DEPTH, 4, command FIFO entries (power of 2, >=2)
DEFAULT_CNTR_WIDTH, 3, timeout counter width
DEFAULT_CNTR_TIMEOUT, 7, terminal timeout count
DEFAULT_READ_VALUE, 32'hBAD_FAB_AC, read data returned on timeout

Ports:
WB_CLK  in  1  single clock; all logic on its rising edge
WB_RST_n  in  1  asynchronous active-low reset
Cmd_Valid_i  in  1  command present
Cmd_Ready_o  out  1  FIFO can accept (= not full)
Cmd_Adr_i  in  ADDRWIDTH  byte address
Cmd_WE_i  in  1  1=write, 0=read
Cmd_Byte_Stb_i  in  4  byte enables
Cmd_Wr_Dat_i  in  DATAWIDTH  write data
Rsp_Valid_o  out  1  response available
Rsp_Ready_i  in  1  response consumed
Rsp_Rd_Dat_o  out  DATAWIDTH  read data (0 for writes)
Rsp_WE_o  out  1  echoes command type
Rsp_Err_o  out  1  cycle timed out
WBs_ADR_o  out  ADDRWIDTH  address
WBs_CYC_o  out  1  cycle
WBs_STB_o  out  1  strobe
WBs_WE_o  out  1  write enable
WBs_RD_o  out  1  read enable
WBs_BYTE_STB_o  out  4  byte selects
WBs_WR_DAT_o  out  DATAWIDTH  write data
WBs_RD_DAT_i  in  DATAWIDTH  read data
WBs_ACK_i  in  1  acknowledge
Busy_o  out  1  FSM not IDLE or FIFO not empty

Behaviour:
- Reset (asynchronous, WB_RST_n=0):
  - All outputs are 0 except Cmd_Ready_o=1 once reset is released.
  - FIFO is emptied, FSM goes to IDLE, timeout counter is 0.
  - An in-flight cycle is abandoned with no response; CYC/STB drop immediately.
- Command FIFO:
  - A push occurs on an edge where Cmd_Valid_i & Cmd_Ready_o.
  - Cmd_Ready_o = !full and is registered-status only; there is no bypass, so a full FIFO never accepts, even if a pop happens in the same cycle.
  - Push and pop in the same edge are allowed when not full.
  - Pointers wrap modulo CMD_FIFO_DEPTH.
- FSM states: IDLE, REQ, RSP.
- IDLE:
  - If the FIFO is non-empty, pop the head and register ADR/WE/BYTE_STB/WR_DAT onto WBs_*.
  - Set CYC=STB=1, WBs_RD_o=!WE, clear the counter, go to REQ.
  - An entry pushed at edge E0 drives CYC high after edge E1.
- REQ:
  - WBs_* are held stable.
  - Each edge with WBs_ACK_i=1:
    - Capture Rsp_Rd_Dat_o = WE ? 0 : WBs_RD_DAT_i, Rsp_Err_o=0, Rsp_WE_o=WE.
    - Clear all WBs_* outputs to 0, set Rsp_Valid_o=1, go to RSP.
  - Each edge with no ACK:
    - If counter == DEFAULT_CNTR_TIMEOUT: abort. Clear WBs_*, Rsp_Rd_Dat_o = WE ? 0 : DEFAULT_READ_VALUE, Rsp_Err_o=1, go to RSP.
    - Otherwise increment the counter.
  - CYC therefore stays high for at most DEFAULT_CNTR_TIMEOUT+1 cycles (8 by default).
  - If ACK arrives on the terminal-count edge, ACK wins (no error).
- RSP:
  - Rsp_* is held stable while Rsp_Valid_o=1.
  - On an edge with Rsp_Ready_i=1: Rsp_Valid_o=0, go to IDLE.
  - The next command issues at the following edge, so there are at least 2 idle cycles between CYC pulses.
  - Rsp_Rd_Dat_o/Rsp_Err_o/Rsp_WE_o keep their last value until the next capture.
- WBs_ACK_i outside REQ is ignored.
- Commands complete strictly in FIFO order, with one outstanding cycle.

Test Plan:
- Single write: cmd ADR=17'h01004, WE=1, STB=4'hF, DAT=32'h000000A5; slave ACKs 2 cycles after CYC rises -> WBs_* match for 3 cycles, then Rsp_Valid=1, Err=0, WE=1, Rd_Dat=0.
- Single read: ADR=17'h00000, slave returns 32'h12345678 with ACK in the first CYC cycle -> WBs_RD_o=1, Rsp_Rd_Dat=32'h12345678, Err=0, CYC high exactly 1 cycle.
- Timeout: read to an unresponsive address -> CYC high exactly 8 cycles, Rsp_Rd_Dat=32'hBAD_FAB_AC, Err=1; ACK on the 8th cycle instead -> Err=0 with slave data.
- Back-pressure/FIFO: push 5 commands back-to-back with Rsp_Ready_i=0 -> 4 accepted, Cmd_Ready_o=0 on the 5th; release Rsp_Ready -> 4 responses in order, then the 5th accepted.
- Reset mid-cycle: assert WB_RST_n=0 while CYC=1 -> CYC/STB/Rsp_Valid=0 without waiting for a clock, FIFO empty; after release, a new read completes normally.
- Stray ACK: pulse WBs_ACK_i in IDLE and in RSP -> no state change and no extra response.
